// File: rtl/mcpu_core_issue_ctl.sv
// Decode-stage issue controller: holds one 4-wide packet and issues it once it is clear of the scoreboard.
// Optional hazard-stall counter enabled by defining MCPU_ISSUE_STALLCNT_EN.
module mcpu_core_issue_ctl #(
  parameter int PAYLOAD_W  = 128,
  parameter int STALLCNT_W = 16
) (
  input  logic                  clkrst_core_clk,
  input  logic                  clkrst_core_rst_n,
  input  logic                  f2d_valid,
  output logic                  d2f_ready,
  input  logic [PAYLOAD_W-1:0]  f2d_payload,
  input  logic [39:0]           f2d_src_num,
  input  logic [7:0]            f2d_src_en,
  input  logic [7:0]            f2d_pred_src,
  input  logic [19:0]           f2d_rd_num,
  input  logic [3:0]            f2d_rd_we,
  input  logic [3:0]            f2d_pred_we,
  input  logic [31:0]           sb2d_reg_scoreboard,
  input  logic [2:0]            sb2d_pred_scoreboard,
  input  logic                  pc_ready,
  input  logic                  pipe_flush,
  input  logic                  exception,
  output logic                  d2pc_progress,
  output logic [PAYLOAD_W-1:0]  d2pc_payload,
  output logic [19:0]           d2pc_out_rd_num,
  output logic [3:0]            d2pc_out_rd_we,
  output logic [3:0]            d2pc_out_pred_we,
  output logic [STALLCNT_W-1:0] issue_stall_cnt,
  input  logic                  issue_stall_clr
);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_HOLD  = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [39:0]          src_num_q, src_num_d;
  logic [7:0]           src_en_q, src_en_d;
  logic [7:0]           pred_src_q, pred_src_d;
  logic [19:0]          rd_num_q, rd_num_d;
  logic [3:0]           rd_we_q, rd_we_d;
  logic [3:0]           pred_we_q, pred_we_d;

  logic       hold, hazard, load;
  logic [3:0] pred_sb;

  assign hold = (state_q == S_HOLD);
  // Predicate 3 is the always-true predicate and is never pending.
  assign pred_sb = {1'b0, sb2d_pred_scoreboard};

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 2; j++)
        if (src_en_q[2*i+j] && sb2d_reg_scoreboard[src_num_q[10*i+5*j +: 5]]) hazard = 1'b1;
      if (pred_src_q[2*i +: 2] != 2'd3 && pred_sb[pred_src_q[2*i +: 2]]) hazard = 1'b1;
      if (rd_we_q[i] && sb2d_reg_scoreboard[rd_num_q[5*i +: 5]]) hazard = 1'b1;
      if (pred_we_q[i] && pred_sb[rd_num_q[5*i +: 2]]) hazard = 1'b1;
    end
    hazard = hazard & hold;
  end

  assign d2pc_progress = hold & ~hazard & pc_ready & ~pipe_flush & ~exception;
  assign d2f_ready     = ~pipe_flush & (~hold | d2pc_progress);
  assign load          = f2d_valid & d2f_ready;

  always_comb begin
    state_d    = state_q;
    payload_d  = payload_q;
    src_num_d  = src_num_q;
    src_en_d   = src_en_q;
    pred_src_d = pred_src_q;
    rd_num_d   = rd_num_q;
    rd_we_d    = rd_we_q;
    pred_we_d  = pred_we_q;
    if (pipe_flush)         state_d = S_EMPTY;
    else if (load)          state_d = S_HOLD;
    else if (d2pc_progress) state_d = S_EMPTY;
    if (load) begin
      payload_d  = f2d_payload;
      src_num_d  = f2d_src_num;
      src_en_d   = f2d_src_en;
      pred_src_d = f2d_pred_src;
      rd_num_d   = f2d_rd_num;
      rd_we_d    = f2d_rd_we;
      pred_we_d  = f2d_pred_we;
    end
  end

  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      state_q    <= S_EMPTY;
      payload_q  <= '0;
      src_num_q  <= '0;
      src_en_q   <= '0;
      pred_src_q <= '0;
      rd_num_q   <= '0;
      rd_we_q    <= '0;
      pred_we_q  <= '0;
    end else begin
      state_q    <= state_d;
      payload_q  <= payload_d;
      src_num_q  <= src_num_d;
      src_en_q   <= src_en_d;
      pred_src_q <= pred_src_d;
      rd_num_q   <= rd_num_d;
      rd_we_q    <= rd_we_d;
      pred_we_q  <= pred_we_d;
    end
  end

  assign d2pc_payload     = payload_q;
  assign d2pc_out_rd_num  = rd_num_q;
  assign d2pc_out_rd_we   = rd_we_q & {4{hold}};
  assign d2pc_out_pred_we = pred_we_q & {4{hold}};

`ifdef MCPU_ISSUE_STALLCNT_EN
  logic [STALLCNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating; clear wins over a same-cycle increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (issue_stall_clr)
      stall_cnt_d = '0;
    else if (hazard && !pipe_flush && stall_cnt_q != {STALLCNT_W{1'b1}})
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) stall_cnt_q <= '0;
    else                    stall_cnt_q <= stall_cnt_d;
  end

  assign issue_stall_cnt = stall_cnt_q;
`else
  logic unused_stall_clr;
  assign unused_stall_clr = issue_stall_clr;
  assign issue_stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_mcpu_core_issue_ctl.sv
// Directed bench for mcpu_core_issue_ctl; inputs change on negedge, outputs checked 1ns later.
module tb_mcpu_core_issue_ctl;
  localparam int SCW = 8;
`ifdef MCPU_ISSUE_STALLCNT_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic f2d_valid = 0, d2f_ready;
  logic [127:0] f2d_payload = '0;
  logic [39:0] f2d_src_num = '0;
  logic [7:0] f2d_src_en = '0, f2d_pred_src = 8'hFF;
  logic [19:0] f2d_rd_num = '0;
  logic [3:0] f2d_rd_we = '0, f2d_pred_we = '0;
  logic [31:0] reg_sb = '0;
  logic [2:0] pred_sb = '0;
  logic pc_ready = 1'b1, pipe_flush = 0, exception = 0, stall_clr = 0;
  logic progress;
  logic [127:0] payload;
  logic [19:0] rd_num;
  logic [3:0] rd_we, pred_we;
  logic [SCW-1:0] stall_cnt;
  int total = 0, bad = 0;

  mcpu_core_issue_ctl #(.PAYLOAD_W(128), .STALLCNT_W(SCW)) dut (
    .clkrst_core_clk(clk), .clkrst_core_rst_n(rst_n),
    .f2d_valid(f2d_valid), .d2f_ready(d2f_ready), .f2d_payload(f2d_payload),
    .f2d_src_num(f2d_src_num), .f2d_src_en(f2d_src_en), .f2d_pred_src(f2d_pred_src),
    .f2d_rd_num(f2d_rd_num), .f2d_rd_we(f2d_rd_we), .f2d_pred_we(f2d_pred_we),
    .sb2d_reg_scoreboard(reg_sb), .sb2d_pred_scoreboard(pred_sb),
    .pc_ready(pc_ready), .pipe_flush(pipe_flush), .exception(exception),
    .d2pc_progress(progress), .d2pc_payload(payload), .d2pc_out_rd_num(rd_num),
    .d2pc_out_rd_we(rd_we), .d2pc_out_pred_we(pred_we),
    .issue_stall_cnt(stall_cnt), .issue_stall_clr(stall_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [SCW-1:0] ec(input int n);
    return FEAT ? SCW'(n) : '0;
  endfunction

  task automatic set_pkt(input logic [127:0] pl, input logic [39:0] sn, input logic [7:0] se,
                         input logic [7:0] ps, input logic [19:0] rn, input logic [3:0] rw,
                         input logic [3:0] pw);
    f2d_valid = 1'b1; f2d_payload = pl; f2d_src_num = sn; f2d_src_en = se;
    f2d_pred_src = ps; f2d_rd_num = rn; f2d_rd_we = rw; f2d_pred_we = pw;
  endtask

  task automatic idle();
    f2d_valid = 1'b0; f2d_payload = '0;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    total++; if (progress !== 1'b0) begin bad++; $display("FAIL rst_progress act=%0h exp=0", progress); end
    total++; if (rd_we !== 4'h0) begin bad++; $display("FAIL rst_rd_we act=%0h exp=0", rd_we); end
    total++; if (pred_we !== 4'h0) begin bad++; $display("FAIL rst_pred_we act=%0h exp=0", pred_we); end
    total++; if (rd_num !== 20'h0) begin bad++; $display("FAIL rst_rd_num act=%0h exp=0", rd_num); end
    total++; if (payload !== 128'h0) begin bad++; $display("FAIL rst_payload act=%0h exp=0", payload); end
    total++; if (stall_cnt !== '0) begin bad++; $display("FAIL rst_stall_cnt act=%0h exp=0", stall_cnt); end
    total++; if (d2f_ready !== 1'b1) begin bad++; $display("FAIL rst_ready act=%0h exp=1", d2f_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_hold();
    @(negedge clk); set_pkt(128'hA5, '0, '0, 8'hFF, 20'h12345, 4'hF, 4'h0); pc_ready = 0;
    @(negedge clk); idle(); #1;
    total++; if (rd_we !== 4'hF) begin bad++; $display("FAIL mh_rd_we act=%0h exp=f", rd_we); end
    total++; if (d2f_ready !== 1'b0) begin bad++; $display("FAIL mh_ready act=%0h exp=0", d2f_ready); end
    rst_n = 1'b0; #1;
    total++; if (rd_we !== 4'h0) begin bad++; $display("FAIL mh_rst_rd_we act=%0h exp=0", rd_we); end
    total++; if (d2f_ready !== 1'b1) begin bad++; $display("FAIL mh_rst_ready act=%0h exp=1", d2f_ready); end
    total++; if (payload !== 128'h0) begin bad++; $display("FAIL mh_rst_payload act=%0h exp=0", payload); end
    @(negedge clk); rst_n = 1'b1; pc_ready = 1; #1;
    total++; if (progress !== 1'b0) begin bad++; $display("FAIL mh_empty_prog act=%0h exp=0", progress); end
  endtask

  task automatic test_raw_stall();
    @(negedge clk); set_pkt(128'h1111, 40'h5, 8'h01, 8'hFF, '0, '0, '0); #1;
    total++; if (d2f_ready !== 1'b1) begin bad++; $display("FAIL raw_ready act=%0h exp=1", d2f_ready); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); idle(); reg_sb = 32'h20; #1;
      total++; if (progress !== 1'b0) begin bad++; $display("FAIL raw_stall%0d act=%0h exp=0", k, progress); end
    end
    @(negedge clk); reg_sb = '0; #1;
    total++; if (progress !== 1'b1) begin bad++; $display("FAIL raw_issue act=%0h exp=1", progress); end
    total++; if (payload !== 128'h1111) begin bad++; $display("FAIL raw_payload act=%0h exp=1111", payload); end
    total++; if (stall_cnt !== ec(3)) begin bad++; $display("FAIL raw_cnt act=%0h exp=%0h", stall_cnt, ec(3)); end
    @(negedge clk); #1;
    total++; if (progress !== 1'b0) begin bad++; $display("FAIL raw_after act=%0h exp=0", progress); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) set_pkt(128'd100 + 128'(k), '0, '0, 8'hFF, 20'(k), 4'h1, 4'h0); else idle();
      #1;
      total++; if (d2f_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d act=%0h exp=1", k, d2f_ready); end
      if (k > 0) begin
        total++; if (progress !== 1'b1) begin bad++; $display("FAIL b2b_prog%0d act=%0h exp=1", k, progress); end
        total++; if (payload !== 128'd99 + 128'(k)) begin bad++; $display("FAIL b2b_payload%0d act=%0d exp=%0d", k, payload, 99 + k); end
      end
    end
    @(negedge clk); #1;
    total++; if (progress !== 1'b0) begin bad++; $display("FAIL b2b_drain act=%0h exp=0", progress); end
  endtask

  task automatic test_pred();
    logic [7:0]  ps [6] = '{8'hFF, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [3:0]  pw [6] = '{4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0};
    logic [3:0]  rw [6] = '{4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0};
    logic [19:0] rn [6] = '{20'h0, 20'h0, 20'h00020, 20'h01C00, 20'h0, 20'h0};
    logic [39:0] sn [6] = '{40'h0, 40'h0, 40'h0, 40'h0, 40'hF800000000, 40'hF800000000};
    logic [7:0]  se [6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h40};
    logic [31:0] rs [6] = '{32'h0, 32'h0, 32'h0, 32'h80, 32'h80000000, 32'h80000000};
    logic [2:0]  qs [6] = '{3'b111, 3'b100, 3'b010, 3'b000, 3'b000, 3'b000};
    logic        st [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); set_pkt(128'(200 + c), sn[c], se[c], ps[c], rn[c], rw[c], pw[c]);
      reg_sb = rs[c]; pred_sb = qs[c];
      @(negedge clk); idle(); #1;
      total++; if (progress !== ~st[c]) begin bad++; $display("FAIL pred_case%0d_prog act=%0h exp=%0h", c, progress, ~st[c]); end
      if (st[c]) begin
        @(negedge clk); reg_sb = '0; pred_sb = '0; #1;
        total++; if (progress !== 1'b1) begin bad++; $display("FAIL pred_case%0d_release act=%0h exp=1", c, progress); end
      end
      reg_sb = '0; pred_sb = '0;
    end
    @(negedge clk); #1;
    total++; if (stall_cnt !== ec(7)) begin bad++; $display("FAIL pred_cnt act=%0h exp=%0h", stall_cnt, ec(7)); end
  endtask

  task automatic test_exception();
    @(negedge clk); set_pkt(128'h2222, '0, '0, 8'hFF, '0, 4'h8, '0);
    @(negedge clk); idle(); exception = 1; #1;
    total++; if (progress !== 1'b0) begin bad++; $display("FAIL exc_prog act=%0h exp=0", progress); end
    total++; if (d2f_ready !== 1'b0) begin bad++; $display("FAIL exc_ready act=%0h exp=0", d2f_ready); end
    @(negedge clk); exception = 0; #1;
    total++; if (progress !== 1'b1) begin bad++; $display("FAIL exc_resume act=%0h exp=1", progress); end
    total++; if (payload !== 128'h2222) begin bad++; $display("FAIL exc_payload act=%0h exp=2222", payload); end
  endtask

  task automatic test_flush();
    @(negedge clk); set_pkt(128'h3333, '0, '0, 8'hFF, '0, 4'h3, '0); pc_ready = 0;
    @(negedge clk); idle(); #1;
    total++; if (rd_we !== 4'h3) begin bad++; $display("FAIL fl_hold_rd_we act=%0h exp=3", rd_we); end
    @(negedge clk); pipe_flush = 1; pc_ready = 1; set_pkt(128'h4444, '0, '0, 8'hFF, '0, 4'h5, '0); #1;
    total++; if (d2f_ready !== 1'b0) begin bad++; $display("FAIL fl_ready act=%0h exp=0", d2f_ready); end
    total++; if (progress !== 1'b0) begin bad++; $display("FAIL fl_prog act=%0h exp=0", progress); end
    @(negedge clk); pipe_flush = 0; idle(); #1;
    total++; if (rd_we !== 4'h0) begin bad++; $display("FAIL fl_empty_rd_we act=%0h exp=0", rd_we); end
    total++; if (d2f_ready !== 1'b1) begin bad++; $display("FAIL fl_empty_ready act=%0h exp=1", d2f_ready); end
    total++; if (payload !== 128'h3333) begin bad++; $display("FAIL fl_not_captured act=%0h exp=3333", payload); end
  endtask

  task automatic test_stallcnt();
    @(negedge clk); set_pkt(128'h5555, 40'h5, 8'h01, 8'hFF, '0, '0, '0);
    @(negedge clk); idle(); reg_sb = 32'h20;
    repeat (260) @(negedge clk);
    #1;
    total++; if (stall_cnt !== ec(255)) begin bad++; $display("FAIL cnt_saturate act=%0h exp=%0h", stall_cnt, ec(255)); end
    stall_clr = 1;
    @(negedge clk); stall_clr = 0; #1;
    total++; if (stall_cnt !== '0) begin bad++; $display("FAIL cnt_clear act=%0h exp=0", stall_cnt); end
    @(negedge clk); #1;
    total++; if (stall_cnt !== ec(1)) begin bad++; $display("FAIL cnt_after_clear act=%0h exp=%0h", stall_cnt, ec(1)); end
    @(negedge clk); reg_sb = '0; #1;
    total++; if (progress !== 1'b1) begin bad++; $display("FAIL cnt_issue act=%0h exp=1", progress); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_hold();
    test_raw_stall();
    test_back_to_back();
    test_pred();
    test_exception();
    test_flush();
    test_stallcnt();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
